note_sequencer: RTL and testbench
=================================

Name: note_sequencer

Overview:
- Upstream stage of the tone synthesis chain.
- Walks a song ROM of {duration, note} entries and emits a 7-bit note code for the frequency generator input (freq_in), one note at a time.
- Note duration is measured in tempo ticks; tick period shrinks as the 4-bit game level rises, so music speeds up with level.
- Emits a per-note strobe and an end-of-song pulse; supports run/pause and synchronous restart.

Parameters:
- ROM_AW, 8, song ROM address width.
- NOTE_W, 7, note code width; code 0 = rest/silence.
- DUR_W, 5, duration field width in ticks; 0 = end-of-song marker.
- BASE_DIV, 3000000, clk cycles per tick at level 0.
- STEP_DIV, 150000, cycles removed from the tick period per level step.
- DIV_W, 24, tick counter width.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- level  in  4  game level 0..15; sets tempo.
- run  in  1  1 = sequence advances, 0 = freeze (pause).
- restart  in  1  one-cycle pulse; rewind to ROM address 0.
- rom_addr  out  ROM_AW  registered address to the synchronous song ROM.
- rom_data  in  DUR_W+NOTE_W  {dur, note}; valid one cycle after rom_addr changes.
- freq_out  out  NOTE_W  current note code to the frequency generator.
- note_strobe  out  1  one-cycle pulse when a new note is loaded.
- song_end  out  1  one-cycle pulse when the end marker is read.

Behaviour:
- Reset (rst=0, async): state IDLE, rom_addr=0, freq_out=0, note_strobe=0, song_end=0, tick and duration counters 0.
- Tick period = BASE_DIV - level*STEP_DIV cycles, computed in DIV_W bits. Level is sampled at each tick boundary; a change takes effect on the next tick.
- FSM states: IDLE, FETCH, LOAD, PLAY, GAP.
  - IDLE: freq_out=0. Go to FETCH when run=1.
  - FETCH: one wait cycle for ROM latency.
  - LOAD: capture rom_data.
    - dur==0: assert song_end for 1 cycle and set freq_out=0. With SEQ_LOOP_EN: set rom_addr=0 and go to FETCH. Without it: go to IDLE and stay stopped until restart.
    - dur!=0: set freq_out=note, pulse note_strobe, set remaining=dur, clear tick counter, set rom_addr=rom_addr+1 (wraps modulo 2^ROM_AW), go to PLAY.
  - PLAY: on each tick, decrement remaining.
    - remaining reaches 1 and loaded dur>1: freq_out=0, go to GAP. This gives a one-tick articulation gap.
    - remaining reaches 0 (dur==1 case): go to FETCH.
  - GAP: on the next tick, go to FETCH.
- Inter-note latency is 2 cycles (FETCH, LOAD). During these cycles freq_out holds its value: 0 after a gap, or the previous note when dur==1.
- run=0 freezes the FSM, tick counter, duration counter and rom_addr. freq_out holds; note_strobe and song_end are 0. Resuming continues mid-tick exactly where the sequence stopped.
- restart=1 has top priority over run, tick and end marker:
  - rom_addr=0, freq_out=0, counters cleared, no song_end.
  - Next state is FETCH if run=1, else IDLE.
  - A restart that coincides with the end-marker LOAD suppresses song_end.
- Note code 0 with dur!=0 is a timed rest: freq_out=0 for the full duration, and note_strobe still pulses.
- Reset asserted mid-note returns to reset values immediately.

Optional Feature:
- Macro SEQ_LOOP_EN.
- Defined: the end marker wraps to address 0 and playback continues seamlessly (song_end still pulses).
- Undefined: the end marker stops the sequencer in IDLE with freq_out=0. It stays there regardless of run until restart.

Decomposition:
- Package seq_pkg holds:
  - FSM state encoding.
  - Field widths: NOTE_W, DUR_W.
  - Constants: REST_CODE=0, END_DUR=0.
  - Field-extract positions within rom_data: note=[NOTE_W-1:0], dur=[NOTE_W+DUR_W-1:NOTE_W].
- Sub-module tempo_tick: level-scaled divider with enable (run) and sync clear. Emits a one-cycle tick.
- note_sequencer contains the FSM, address and duration counters.

Test Plan:
- Common bench settings: BASE_DIV=8, STEP_DIV=1; ROM = {dur2,n10},{dur1,n20},{dur3,n0},{dur0}.
1. Reset then run=1, level=0 → note_strobe at cycle 2, freq_out=10 for 8 cycles, then 0 for 8 cycles. freq_out=20 strobes 2 cycles later and lasts 8 cycles with no gap.
2. Same run, continuing → rest entry strobes with freq_out=0 for 24 cycles; song_end pulses once. With SEQ_LOOP_EN, freq_out=10 reappears 2 cycles later; without it, the FSM stays in IDLE with freq_out=0.
3. level=4 → tick = 4 cycles; first note is 4 on + 4 gap. Changing level 4→0 mid-note applies from the next tick only.
4. Drop run for 20 cycles mid-note 10 → freq_out holds 10, no strobes. After release, the remaining tick time completes exactly.
5. Pulse restart during note 20 → next cycle freq_out=0, rom_addr=0; note 10 strobes 2 cycles later.
6. Assert restart in the same cycle the end marker is loaded → no song_end; playback starts from address 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the note sequencer: FSM state encoding and the
// {dur, note} layout of a song ROM word.
package seq_pkg;

  localparam int NOTE_W = 7;
  localparam int DUR_W  = 5;
  localparam int ROM_DW = NOTE_W + DUR_W;

  localparam logic [NOTE_W-1:0] REST_CODE = '0;
  localparam logic [DUR_W-1:0]  END_DUR   = '0;

  localparam int NOTE_LSB = 0;
  localparam int NOTE_MSB = NOTE_W - 1;
  localparam int DUR_LSB  = NOTE_W;
  localparam int DUR_MSB  = NOTE_W + DUR_W - 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY,
    GAP
  } seq_state_e;

endpackage

// File: rtl/note_sequencer_if.sv
// Song ROM bus between the sequencer (master, drives the address) and a
// synchronous ROM (slave, returns the word one cycle later).
interface note_sequencer_if #(
  parameter int ROM_AW = 8,
  parameter int DATA_W = seq_pkg::ROM_DW
);

  logic [ROM_AW-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    output rom_data
  );

endinterface

// File: rtl/tempo_tick.sv
// Level-scaled tempo divider: one-cycle tick every BASE_DIV - level*STEP_DIV
// enabled cycles; level is resampled on every tick and on clear.
module tempo_tick #(
  parameter int BASE_DIV = 3000000,
  parameter int STEP_DIV = 150000,
  parameter int DIV_W    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] level,
  input  logic       en,
  input  logic       clear,
  output logic       tick
);

  localparam logic [DIV_W-1:0] BASE = DIV_W'(BASE_DIV);
  localparam logic [DIV_W-1:0] STEP = DIV_W'(STEP_DIV);

  logic [DIV_W-1:0] cnt_q;
  logic [3:0]       level_q;
  logic [DIV_W-1:0] period_m1;

  // The period in force is set by the level latched at the last boundary,
  // so a mid-tick level change cannot stretch or cut the current tick.
  assign period_m1 = BASE - STEP * DIV_W'(level_q) - DIV_W'(1);
  assign tick      = en && (cnt_q == period_m1);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      level_q <= '0;
    end else if (clear || tick) begin
      cnt_q   <= '0;
      level_q <= level;
    end else if (en) begin
      cnt_q   <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Song ROM walker feeding the tone generator. Optional macro SEQ_LOOP_EN:
// defined = end marker wraps to address 0, undefined = stop in IDLE until restart.
module note_sequencer #(
  parameter int ROM_AW   = 8,
  parameter int NOTE_W   = seq_pkg::NOTE_W,
  parameter int DUR_W    = seq_pkg::DUR_W,
  parameter int BASE_DIV = 3000000,
  parameter int STEP_DIV = 150000,
  parameter int DIV_W    = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        level,
  input  logic              run,
  input  logic              restart,
  note_sequencer_if.master  rom,
  output logic [NOTE_W-1:0] freq_out,
  output logic              note_strobe,
  output logic              song_end
);

  import seq_pkg::*;

  seq_state_e        state_q, state_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [NOTE_W-1:0] freq_q, freq_d;
  logic [DUR_W-1:0]  rem_q, rem_d;
  logic              strobe_q, strobe_d;
  logic              end_q, end_d;
  logic              halted_q, halted_d;
  logic              tick;
  logic              tick_clear;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  assign rom_note = rom.rom_data[NOTE_MSB:NOTE_LSB];
  assign rom_dur  = rom.rom_data[DUR_MSB:DUR_LSB];

  // Each note's first tick is measured from its LOAD cycle.
  assign tick_clear = restart || (run && (state_q == LOAD));

  tempo_tick #(
    .BASE_DIV (BASE_DIV),
    .STEP_DIV (STEP_DIV),
    .DIV_W    (DIV_W)
  ) u_tempo_tick (
    .clk   (clk),
    .rst   (rst),
    .level (level),
    .en    (run),
    .clear (tick_clear),
    .tick  (tick)
  );

  // NOTE: every always_comb output is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    freq_d   = freq_q;
    rem_d    = rem_q;
    halted_d = halted_q;
    strobe_d = 1'b0;
    end_d    = 1'b0;

    if (restart) begin
      addr_d   = '0;
      freq_d   = REST_CODE;
      rem_d    = '0;
      halted_d = 1'b0;
      state_d  = run ? FETCH : IDLE;
    end else if (run) begin
      unique case (state_q)
        IDLE: begin
          if (!halted_q) state_d = FETCH;
        end
        FETCH: begin
          state_d = LOAD;
        end
        LOAD: begin
          if (rom_dur == END_DUR) begin
            end_d  = 1'b1;
            freq_d = REST_CODE;
`ifdef SEQ_LOOP_EN
            addr_d  = '0;
            state_d = FETCH;
`else
            halted_d = 1'b1;
            state_d  = IDLE;
`endif
          end else begin
            freq_d   = rom_note;
            strobe_d = 1'b1;
            rem_d    = rom_dur;
            addr_d   = addr_q + ROM_AW'(1);
            state_d  = PLAY;
          end
        end
        PLAY: begin
          if (tick) begin
            rem_d = rem_q - DUR_W'(1);
            if (rem_q == DUR_W'(1)) begin
              state_d = FETCH;
            end else if (rem_q == DUR_W'(2)) begin
              // Last tick of a multi-tick note is silent articulation.
              freq_d  = REST_CODE;
              state_d = GAP;
            end
          end
        end
        GAP: begin
          if (tick) begin
            rem_d   = '0;
            state_d = FETCH;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      freq_q   <= '0;
      rem_q    <= '0;
      strobe_q <= 1'b0;
      end_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      freq_q   <= freq_d;
      rem_q    <= rem_d;
      strobe_q <= strobe_d;
      end_q    <= end_d;
      halted_q <= halted_d;
    end
  end

  assign rom.rom_addr = addr_q;
  assign freq_out     = freq_q;
  assign note_strobe  = strobe_q;
  assign song_end     = end_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer: fixed-song vector table, hand-written
// corner sequences, and randomized songs/pauses against a timeline model.
module tb_note_sequencer;

`ifdef SEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam int BASE = 8;
  localparam int STEP = 1;

  logic       clk;
  logic       rst;
  logic [3:0] level;
  logic       run;
  logic       restart;
  logic [6:0] freq_out;
  logic       note_strobe;
  logic       song_end;

  int tests;
  int failed;

  logic [11:0] rom_mem [0:255];

  note_sequencer_if #(.ROM_AW(8), .DATA_W(12)) rom_if ();

  note_sequencer #(
    .ROM_AW   (8),
    .NOTE_W   (7),
    .DUR_W    (5),
    .BASE_DIV (BASE),
    .STEP_DIV (STEP),
    .DIV_W    (24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .level       (level),
    .run         (run),
    .restart     (restart),
    .rom         (rom_if),
    .freq_out    (freq_out),
    .note_strobe (note_strobe),
    .song_end    (song_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_if.rom_data <= rom_mem[rom_if.rom_addr];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string name, input int f, input bit s, input bit e);
    check({name, ".freq"}, 32'(freq_out), 32'(f));
    check({name, ".strobe"}, 32'(note_strobe), 32'(s));
    check({name, ".end"}, 32'(song_end), 32'(e));
  endtask

  task automatic reset_dut(input logic [3:0] lv);
    rst = 1'b0;
    run = 1'b0;
    restart = 1'b0;
    level = lv;
    adv(3);
    rst = 1'b1;
  endtask

  task automatic load_fixed_song();
    for (int i = 0; i < 256; i++) rom_mem[i] = '0;
    rom_mem[0] = {5'd2, 7'd10};
    rom_mem[1] = {5'd1, 7'd20};
    rom_mem[2] = {5'd3, 7'd0};
    rom_mem[3] = {5'd0, 7'd0};
  endtask

  // ---------------- vector table for the fixed song at level 0 ----------------
  typedef struct {
    string name;
    int    adv;
    bit    run;
    int    freq;
    bit    strobe;
    bit    send;
    int    addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string nm, input int a, input bit r, input int f,
                         input bit s, input bit e, input int ad);
    vec_t v;
    v.name = nm; v.adv = a; v.run = r; v.freq = f; v.strobe = s; v.send = e; v.addr = ad;
    vecs.push_back(v);
  endtask

  // ---------------- timeline model for randomized songs ----------------
  typedef struct {
    int freq;
    bit strobe;
    bit send;
  } obs_t;

  obs_t trace[$];
  int   song_dur[$];
  int   song_note[$];

  task automatic push_obs(input int f, input bit s, input bit e, input int count);
    obs_t o;
    o.freq = f; o.strobe = s; o.send = e;
    for (int k = 0; k < count; k++) trace.push_back(o);
  endtask

  // trace[n] is the expected output after n run-enabled clock edges.
  task automatic build_trace(input int p);
    int passes;
    int last_f;
    passes = LOOP ? 2 : 1;
    trace.delete();
    push_obs(0, 1'b0, 1'b0, 3);
    for (int pass = 0; pass < passes; pass++) begin
      for (int i = 0; i <= song_dur.size(); i++) begin
        if (i == song_dur.size()) begin
          push_obs(0, 1'b0, 1'b1, 1);
          push_obs(0, 1'b0, 1'b0, LOOP ? 1 : 10);
        end else if (song_dur[i] == 1) begin
          last_f = song_note[i];
          push_obs(last_f, 1'b1, 1'b0, 1);
          push_obs(last_f, 1'b0, 1'b0, p + 1);
        end else begin
          last_f = song_note[i];
          push_obs(last_f, 1'b1, 1'b0, 1);
          push_obs(last_f, 1'b0, 1'b0, (song_dur[i] - 1) * p - 1);
          push_obs(0, 1'b0, 1'b0, p + 2);
        end
      end
    end
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst = 1'b1;
    run = 1'b0;
    restart = 1'b0;
    level = 4'd0;
    #1;

    // ---------------- reset state ----------------
    load_fixed_song();
    reset_dut(4'd0);
    expect_out("reset", 0, 1'b0, 1'b0);
    check("reset.addr", 32'(rom_if.rom_addr), 32'd0);

    // ---------------- fixed song, level 0 (tick = 8) ----------------
    add_vec("n2_fetch",     2, 1'b1, 0,  1'b0, 1'b0, 0);
    add_vec("n3_load10",    1, 1'b1, 10, 1'b1, 1'b0, 1);
    add_vec("n10_last10",   7, 1'b1, 10, 1'b0, 1'b0, 1);
    add_vec("n11_gap",      1, 1'b1, 0,  1'b0, 1'b0, 1);
    add_vec("n20_latency",  9, 1'b1, 0,  1'b0, 1'b0, 1);
    add_vec("n21_load20",   1, 1'b1, 20, 1'b1, 1'b0, 2);
    add_vec("n30_hold20",   9, 1'b1, 20, 1'b0, 1'b0, 2);
    add_vec("n31_rest",     1, 1'b1, 0,  1'b1, 1'b0, 3);
    add_vec("n56_restend", 25, 1'b1, 0,  1'b0, 1'b0, 3);
    add_vec("n57_songend",  1, 1'b1, 0,  1'b0, 1'b1, LOOP ? 0 : 3);
    add_vec("n58_after",    1, 1'b1, 0,  1'b0, 1'b0, LOOP ? 0 : 3);
    add_vec("n59_again",    1, 1'b1, LOOP ? 10 : 0, LOOP, 1'b0, LOOP ? 1 : 3);
    add_vec("n64_settle",   5, 1'b1, LOOP ? 10 : 0, 1'b0, 1'b0, LOOP ? 1 : 3);

    foreach (vecs[i]) begin
      run = vecs[i].run;
      adv(vecs[i].adv);
      expect_out(vecs[i].name, vecs[i].freq, vecs[i].strobe, vecs[i].send);
      check({vecs[i].name, ".addr"}, 32'(rom_if.rom_addr), 32'(vecs[i].addr));
    end

    // ---------------- level 4 (tick = 4), level drops to 0 mid-note ----------------
    reset_dut(4'd4);
    run = 1'b1;
    adv(3);
    expect_out("lvl.n3", 10, 1'b1, 1'b0);
    adv(1);
    level = 4'd0;
    adv(2);
    expect_out("lvl.n6", 10, 1'b0, 1'b0);
    adv(1);
    expect_out("lvl.n7_gap", 0, 1'b0, 1'b0);
    adv(9);
    expect_out("lvl.n16", 0, 1'b0, 1'b0);
    adv(1);
    expect_out("lvl.n17_load20", 20, 1'b1, 1'b0);

    // ---------------- pause mid-note ----------------
    reset_dut(4'd0);
    run = 1'b1;
    adv(5);
    expect_out("pause.n5", 10, 1'b0, 1'b0);
    run = 1'b0;
    for (int k = 0; k < 20; k++) begin
      adv(1);
      check("pause.hold.freq", 32'(freq_out), 32'd10);
      check("pause.hold.strobe", 32'(note_strobe), 32'd0);
    end
    check("pause.addr", 32'(rom_if.rom_addr), 32'd1);
    run = 1'b1;
    adv(5);
    expect_out("pause.n10", 10, 1'b0, 1'b0);
    adv(1);
    expect_out("pause.n11_gap", 0, 1'b0, 1'b0);

    // ---------------- restart during note 20 ----------------
    reset_dut(4'd0);
    run = 1'b1;
    adv(25);
    expect_out("rs.n25", 20, 1'b0, 1'b0);
    restart = 1'b1;
    adv(1);
    restart = 1'b0;
    expect_out("rs.after", 0, 1'b0, 1'b0);
    check("rs.addr", 32'(rom_if.rom_addr), 32'd0);
    adv(1);
    expect_out("rs.load", 0, 1'b0, 1'b0);
    adv(1);
    expect_out("rs.note10", 10, 1'b1, 1'b0);
    check("rs.addr1", 32'(rom_if.rom_addr), 32'd1);

    // ---------------- restart coinciding with end-marker load ----------------
    reset_dut(4'd0);
    run = 1'b1;
    adv(56);
    check("rse.n56.addr", 32'(rom_if.rom_addr), 32'd3);
    restart = 1'b1;
    adv(1);
    restart = 1'b0;
    expect_out("rse.n57", 0, 1'b0, 1'b0);
    check("rse.addr", 32'(rom_if.rom_addr), 32'd0);
    adv(2);
    expect_out("rse.note10", 10, 1'b1, 1'b0);

    // ---------------- asynchronous reset mid-note ----------------
    reset_dut(4'd0);
    run = 1'b1;
    adv(5);
    #2;
    rst = 1'b0;
    #1;
    expect_out("arst", 0, 1'b0, 1'b0);
    check("arst.addr", 32'(rom_if.rom_addr), 32'd0);

    // ---------------- randomized songs, levels and pauses ----------------
    for (int it = 0; it < 6; it++) begin
      int nn, lv, n, cyc, last, fails_before;
      bit go, bad;
      obs_t exp_o;
      nn = $urandom_range(2, 6);
      lv = $urandom_range(0, 6);
      song_dur.delete();
      song_note.delete();
      for (int i = 0; i < 256; i++) rom_mem[i] = '0;
      for (int i = 0; i < nn; i++) begin
        int d, nt;
        d  = $urandom_range(1, 3);
        nt = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 127);
        song_dur.push_back(d);
        song_note.push_back(nt);
        rom_mem[i] = {5'(d), 7'(nt)};
      end
      build_trace(BASE - lv * STEP);
      reset_dut(4'(lv));
      n = 0;
      cyc = 0;
      bad = 1'b0;
      last = trace.size() - 1;
      while (n < last && cyc < 4000 && !bad) begin
        go = ($urandom_range(0, 3) != 0);
        run = go;
        adv(1);
        cyc++;
        if (go) n++;
        exp_o = trace[n];
        if (!go) begin
          exp_o.strobe = 1'b0;
          exp_o.send = 1'b0;
        end
        fails_before = failed;
        check($sformatf("rand%0d.n%0d.freq", it, n), 32'(freq_out), 32'(exp_o.freq));
        check($sformatf("rand%0d.n%0d.strobe", it, n), 32'(note_strobe), 32'(exp_o.strobe));
        check($sformatf("rand%0d.n%0d.end", it, n), 32'(song_end), 32'(exp_o.send));
        if (failed != fails_before) bad = 1'b1;
      end
      if (!bad) check($sformatf("rand%0d.progress", it), 32'(n), 32'(last));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
